// File: rtl/memacc_seq_pkg.sv
// memacc_seq_pkg: shared types and constants for the MEMACC write sequencer.
// Holds the FSM state type, FIFO entry-type codes and FIFO CSR bit positions.
package memacc_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic c_AD_SEL_ADDR = 1'b0;
  localparam logic c_AD_SEL_DATA = 1'b1;

  localparam int c_FIFO_FULL  = 16;
  localparam int c_FIFO_EMPTY = 17;

endpackage

// File: rtl/memacc_sequencer.sv
// memacc_sequencer: drains address/data entries from the MEMACC FIFO into memory writes.
// Ports: wb_clk_i/rst_n_i, enable_i, FIFO read side (fifo_*), memory write side (mem_*),
// status: cur_addr_o, wr_count_o, busy_o, sticky timeout_o with timeout_clr_i.
module memacc_sequencer
  import memacc_seq_pkg::*;
#(
  parameter int g_addr_width = 32,
  parameter int g_timeout    = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic                    fifo_empty_i,
  output logic                    fifo_rd_req_o,
  input  logic                    fifo_ad_sel_i,
  input  logic [31:0]             fifo_ad_i,
  output logic [g_addr_width-1:0] mem_addr_o,
  output logic [31:0]             mem_data_o,
  output logic                    mem_we_o,
  input  logic                    mem_ack_i,
  output logic [g_addr_width-1:0] cur_addr_o,
  output logic [15:0]             wr_count_o,
  output logic                    busy_o,
  output logic                    timeout_o,
  input  logic                    timeout_clr_i
);

  localparam int TW = $clog2(g_timeout + 1);
  // Fire on the WRITE cycle in which the count would reach g_timeout.
  localparam logic [TW-1:0] TMO_LAST = TW'(g_timeout - 1);

  state_t state, state_nx;

  logic [g_addr_width-1:0] cur_addr;
  logic [TW-1:0]           tmo_cnt;
  logic                    is_write;
  logic                    is_addr;
  logic                    ack_hit;
  logic                    tmo_hit;

  assign is_write = (state == S_WRITE);
  assign is_addr  = (fifo_ad_sel_i == c_AD_SEL_ADDR);
  assign ack_hit  = is_write && mem_ack_i;
  // Ack has priority over a timeout in the same cycle.
  assign tmo_hit  = is_write && !mem_ack_i && (tmo_cnt == TMO_LAST);

  // Gated by reset so no fetch is requested while held in reset.
  assign fifo_rd_req_o = rst_n_i && (state == S_IDLE) &&
                         enable_i && !fifo_empty_i;

  assign mem_we_o   = is_write;
  assign busy_o     = (state != S_IDLE);
  assign cur_addr_o = cur_addr;

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (fifo_rd_req_o) state_nx = S_LATCH;
      end
      S_LATCH: begin
        state_nx = is_addr ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        if (ack_hit || tmo_hit) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur_addr   <= '0;
      wr_count_o <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      tmo_cnt    <= '0;
      timeout_o  <= 1'b0;
    end else begin
      if (state == S_LATCH) begin
        unique case (1'b1)
          (fifo_ad_sel_i == c_AD_SEL_ADDR): begin
            cur_addr <= fifo_ad_i[g_addr_width-1:0];
          end
          (fifo_ad_sel_i == c_AD_SEL_DATA): begin
            mem_data_o <= fifo_ad_i;
            mem_addr_o <= cur_addr;
            tmo_cnt    <= '0;
          end
          default: ;
        endcase
      end
      if (ack_hit) begin
        cur_addr   <= cur_addr + g_addr_width'(1);
        wr_count_o <= wr_count_o + 16'd1;
      end else if (is_write) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (tmo_hit) begin
        timeout_o <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memacc_sequencer.sv
// tb_memacc_sequencer: randomized and directed bench for memacc_sequencer.
// A FIFO/memory environment drives the DUT; a transaction-level model predicts outputs.
module tb_memacc_sequencer;

  localparam int TMO = 8;

  logic        clk;
  logic        rst_n_i;
  logic        enable_i;
  logic        fifo_empty_i;
  logic        fifo_rd_req_o;
  logic        fifo_ad_sel_i;
  logic [31:0] fifo_ad_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_we_o;
  logic        mem_ack_i;
  logic [31:0] cur_addr_o;
  logic [15:0] wr_count_o;
  logic        busy_o;
  logic        timeout_o;
  logic        timeout_clr_i;

  memacc_sequencer #(
    .g_addr_width(32),
    .g_timeout   (TMO)
  ) dut (
    .wb_clk_i     (clk),
    .rst_n_i      (rst_n_i),
    .enable_i     (enable_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_req_o(fifo_rd_req_o),
    .fifo_ad_sel_i(fifo_ad_sel_i),
    .fifo_ad_i    (fifo_ad_i),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_we_o     (mem_we_o),
    .mem_ack_i    (mem_ack_i),
    .cur_addr_o   (cur_addr_o),
    .wr_count_o   (wr_count_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .timeout_clr_i(timeout_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] ad;
    int          dly;
  } ent_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  ent_t q[$];
  ent_t jobs[$];
  wr_t  obs[$];

  int errors = 0;
  int checks = 0;

  logic junk_ack = 1'b1;
  logic drv_rd;
  logic prev_we = 1'b0;
  int   wcyc = 0;
  int   cur_dly = 0;

  logic [31:0] m_addr = '0;
  logic [15:0] m_cnt = '0;
  logic        m_tmo = 1'b0;
  logic        active = 1'b0;
  int          age = 0;
  ent_t        j;
  logic        clr_prev = 1'b0;
  int          run_len = 0;
  int          last_len = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic sel, input logic [31:0] ad, input int dly);
    ent_t e;
    e.sel = sel;
    e.ad  = ad;
    e.dly = dly;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q.size() != 0 || busy_o || jobs.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: budget %0d expired", budget);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic wait_we(input int budget);
    int n = 0;
    while (!mem_we_o && n < budget) begin
      tick();
      n++;
    end
    chk("reach_write", {63'd0, mem_we_o}, 64'd1);
  endtask

  // FIFO read side and memory responder.
  initial begin
    fifo_empty_i  = 1'b1;
    fifo_ad_sel_i = 1'b0;
    fifo_ad_i     = '0;
    mem_ack_i     = 1'b0;
    forever begin
      @(negedge clk);
      drv_rd = fifo_rd_req_o;
      @(posedge clk);
      #1;
      if (drv_rd && rst_n_i && q.size() != 0) begin
        ent_t e;
        e = q.pop_front();
        fifo_ad_sel_i = e.sel;
        fifo_ad_i     = e.ad;
        if (e.sel) cur_dly = e.dly;
        jobs.push_back(e);
      end
      fifo_empty_i = (q.size() == 0);
      if (mem_we_o) begin
        wcyc = prev_we ? wcyc + 1 : 0;
        mem_ack_i = (wcyc == cur_dly);
      end else begin
        mem_ack_i = junk_ack ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      prev_we = mem_we_o;
    end
  end

  // Transaction-level model and per-cycle compare.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n_i) begin
        m_addr   = '0;
        m_cnt    = '0;
        m_tmo    = 1'b0;
        active   = 1'b0;
        clr_prev = 1'b0;
        run_len  = 0;
        jobs.delete();
      end else begin
        logic tmo_set;
        logic exp_we;
        logic exp_rd;
        tmo_set = 1'b0;
        if (mem_we_o && mem_ack_i) begin
          wr_t w;
          w.a = mem_addr_o;
          w.d = mem_data_o;
          obs.push_back(w);
        end
        if (mem_we_o) begin
          run_len++;
        end else if (run_len > 0) begin
          last_len = run_len;
          run_len  = 0;
        end
        if (active) begin
          age++;
          if (!j.sel) begin
            if (age == 1) begin
              m_addr = j.ad;
              active = 1'b0;
            end
          end else begin
            int done_at;
            done_at = (j.dly < TMO) ? j.dly + 2 : TMO + 1;
            if (age == done_at) begin
              active = 1'b0;
              if (j.dly < TMO) begin
                m_addr = m_addr + 32'd1;
                m_cnt  = m_cnt + 16'd1;
              end else begin
                tmo_set = 1'b1;
              end
            end
          end
        end
        if (tmo_set) m_tmo = 1'b1;
        else if (clr_prev) m_tmo = 1'b0;
        if (!active && jobs.size() != 0) begin
          j      = jobs.pop_front();
          active = 1'b1;
          age    = 0;
        end
        exp_we = active && j.sel && (age >= 1);
        exp_rd = !active && enable_i && !fifo_empty_i;
        chk("busy", {63'd0, busy_o}, {63'd0, active});
        chk("we", {63'd0, mem_we_o}, {63'd0, exp_we});
        chk("rd_req", {63'd0, fifo_rd_req_o}, {63'd0, exp_rd});
        chk("cur_addr", {32'd0, cur_addr_o}, {32'd0, m_addr});
        chk("wr_count", {48'd0, wr_count_o}, {48'd0, m_cnt});
        chk("timeout", {63'd0, timeout_o}, {63'd0, m_tmo});
        if (exp_we) begin
          chk("mem_addr", {32'd0, mem_addr_o}, {32'd0, m_addr});
          chk("mem_data", {32'd0, mem_data_o}, {32'd0, j.ad});
        end
        clr_prev = timeout_clr_i;
      end
    end
  end

  initial begin
    int n;
    rst_n_i       = 1'b0;
    enable_i      = 1'b1;
    timeout_clr_i = 1'b0;
    repeat (3) tick();
    push(1'b1, 32'h55, 0);
    tick();
    @(negedge clk);
    #1;
    chk("rst_rd_req", {63'd0, fifo_rd_req_o}, 64'd0);
    chk("rst_cur_addr", {32'd0, cur_addr_o}, 64'd0);
    chk("rst_wr_count", {48'd0, wr_count_o}, 64'd0);
    chk("rst_we", {63'd0, mem_we_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_timeout", {63'd0, timeout_o}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr_o}, 64'd0);
    tick();
    rst_n_i = 1'b1;
    wait_idle(100);
    chk("pre_addr_wr_a", {32'd0, obs[0].a}, 64'h0);
    chk("pre_addr_wr_d", {32'd0, obs[0].d}, 64'h55);

    push(1'b0, 32'h100, 0);
    push(1'b1, 32'hA, 0);
    push(1'b1, 32'hB, 0);
    wait_idle(100);
    chk("basic_wr1_a", {32'd0, obs[1].a}, 64'h100);
    chk("basic_wr1_d", {32'd0, obs[1].d}, 64'hA);
    chk("basic_wr2_a", {32'd0, obs[2].a}, 64'h101);
    chk("basic_wr2_d", {32'd0, obs[2].d}, 64'hB);
    chk("basic_cur", {32'd0, cur_addr_o}, 64'h102);
    chk("basic_cnt", {48'd0, wr_count_o}, 64'd3);

    push(1'b1, 32'hC, 5);
    wait_idle(100);
    chk("delay_we_len", 64'(last_len), 64'd6);
    chk("delay_wr_a", {32'd0, obs[3].a}, 64'h102);
    chk("delay_cnt", {48'd0, wr_count_o}, 64'd4);

    push(1'b1, 32'hD, 99);
    wait_idle(100);
    chk("tmo_we_len", 64'(last_len), 64'd8);
    chk("tmo_flag", {63'd0, timeout_o}, 64'd1);
    chk("tmo_cnt", {48'd0, wr_count_o}, 64'd4);
    chk("tmo_cur", {32'd0, cur_addr_o}, 64'h103);
    tick();
    timeout_clr_i = 1'b1;
    tick();
    timeout_clr_i = 1'b0;
    @(negedge clk);
    #1;
    chk("tmo_clr", {63'd0, timeout_o}, 64'd0);

    push(1'b1, 32'hE, 7);
    wait_idle(100);
    chk("late_ack_len", 64'(last_len), 64'd8);
    chk("late_ack_tmo", {63'd0, timeout_o}, 64'd0);
    chk("late_ack_cnt", {48'd0, wr_count_o}, 64'd5);

    timeout_clr_i = 1'b1;
    push(1'b1, 32'hF, 99);
    n = 0;
    while (!timeout_o && n < 100) begin
      tick();
      n++;
    end
    timeout_clr_i = 1'b0;
    @(negedge clk);
    #1;
    chk("set_beats_clr", {63'd0, timeout_o}, 64'd1);
    tick();
    timeout_clr_i = 1'b1;
    tick();
    timeout_clr_i = 1'b0;
    wait_idle(100);

    push(1'b0, 32'hFFFF_FFFF, 0);
    push(1'b1, 32'h1, 0);
    push(1'b1, 32'h2, 0);
    wait_idle(100);
    chk("wrap_wr1_a", {32'd0, obs[5].a}, 64'hFFFF_FFFF);
    chk("wrap_wr2_a", {32'd0, obs[6].a}, 64'h0);
    chk("wrap_cur", {32'd0, cur_addr_o}, 64'h1);
    chk("wrap_cnt", {48'd0, wr_count_o}, 64'd7);

    push(1'b1, 32'h77, 3);
    push(1'b1, 32'h88, 0);
    wait_we(50);
    enable_i = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("en_low_rd", {63'd0, fifo_rd_req_o}, 64'd0);
    end
    chk("en_low_cnt", {48'd0, wr_count_o}, 64'd8);
    tick();
    enable_i = 1'b1;
    wait_idle(100);
    chk("en_back_cnt", {48'd0, wr_count_o}, 64'd9);

    for (int c = 0; c < 1500; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0 && q.size() < 6) begin
        if ($urandom_range(0, 4) == 0)
          push(1'b0, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, 0);
        else
          push(1'b1, $urandom, $urandom_range(0, 9));
      end
      if ($urandom_range(0, 15) == 0) enable_i = ~enable_i;
      timeout_clr_i = ($urandom_range(0, 9) == 0);
    end
    enable_i      = 1'b1;
    timeout_clr_i = 1'b0;
    wait_idle(3000);

    push(1'b1, 32'hDEAD_BEEF, 99);
    wait_we(50);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("rstw_we", {63'd0, mem_we_o}, 64'd0);
    chk("rstw_busy", {63'd0, busy_o}, 64'd0);
    chk("rstw_cur", {32'd0, cur_addr_o}, 64'd0);
    chk("rstw_cnt", {48'd0, wr_count_o}, 64'd0);
    chk("rstw_maddr", {32'd0, mem_addr_o}, 64'd0);
    chk("rstw_mdata", {32'd0, mem_data_o}, 64'd0);
    chk("rstw_tmo", {63'd0, timeout_o}, 64'd0);
    chk("rstw_rd", {63'd0, fifo_rd_req_o}, 64'd0);
    tick();
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_we", {63'd0, mem_we_o}, 64'd0);
    chk("post_rst_cnt", {48'd0, wr_count_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memacc_sequencer.md
MEMACC_SEQUENCER -- requirements
Module: memacc_sequencer

Interface

- REQ-001 The block SHALL have parameter g_addr_width, default 32, giving the width of the memory address and address counter.
- REQ-002 The block SHALL have parameter g_timeout, default 255, giving the maximum number of cycles to wait for mem_ack_i.
- REQ-003 The block SHALL have port wb_clk_i, input, 1 bit: the single system clock; all logic is on its rising edge.
- REQ-004 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
- REQ-005 The block SHALL have port enable_i, input, 1 bit: permits new FIFO fetches.
- REQ-006 The block SHALL have port fifo_empty_i, input, 1 bit: the MEMACC FIFO read-side empty flag.
- REQ-007 The block SHALL have port fifo_rd_req_o, output, 1 bit: FIFO read request; the entry is valid one cycle later.
- REQ-008 The block SHALL have port fifo_ad_sel_i, input, 1 bit: entry type, 0 = set address, 1 = write data.
- REQ-009 The block SHALL have port fifo_ad_i, input, 32 bits: entry payload, either an address or data.
- REQ-010 The block SHALL have port mem_addr_o, output, g_addr_width bits: the write address.
- REQ-011 The block SHALL have port mem_data_o, output, 32 bits: the write data.
- REQ-012 The block SHALL have port mem_we_o, output, 1 bit: write strobe, held until acknowledged.
- REQ-013 The block SHALL have port mem_ack_i, input, 1 bit: write acknowledge from memory.
- REQ-014 The block SHALL have port cur_addr_o, output, g_addr_width bits: the current address counter.
- REQ-015 The block SHALL have port wr_count_o, output, 16 bits: the count of completed writes.
- REQ-016 The block SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.
- REQ-017 The block SHALL have port timeout_o, output, 1 bit: a sticky write-timeout flag.
- REQ-018 The block SHALL have port timeout_clr_i, input, 1 bit: a synchronous clear for timeout_o.

Function

- REQ-019 The FSM SHALL have exactly three states: IDLE, LATCH and WRITE.
- REQ-020 fifo_rd_req_o SHALL be combinational and equal (state = IDLE) AND enable_i AND NOT fifo_empty_i.
- REQ-021 In IDLE, the FSM SHALL move to LATCH when fifo_rd_req_o is high, and SHALL remain in IDLE otherwise.
- REQ-022 In LATCH, when fifo_ad_sel_i = 0, the block SHALL load cur_addr from fifo_ad_i[g_addr_width-1:0] and return to IDLE; an address entry therefore costs 2 cycles.
- REQ-023 In LATCH, when fifo_ad_sel_i = 1, the block SHALL register mem_data_o from fifo_ad_i, drive mem_addr_o from cur_addr, and enter WRITE.
- REQ-024 mem_we_o SHALL be high exactly while in WRITE; mem_addr_o and mem_data_o SHALL remain stable throughout WRITE.
- REQ-025 In WRITE, when mem_ack_i is high, including in the first WRITE cycle, the block SHALL:
  - increment cur_addr modulo 2^g_addr_width, so all-ones wraps to 0;
  - increment wr_count_o modulo 2^16;
  - return to IDLE.
- REQ-026 mem_ack_i SHALL be ignored outside WRITE.
- REQ-027 A timeout counter SHALL clear on entry to WRITE and count every WRITE cycle without an ack.
- REQ-028 When the timeout counter reaches g_timeout, the block SHALL:
  - drop the write;
  - set timeout_o;
  - leave cur_addr and wr_count unchanged;
  - return to IDLE.
- REQ-029 If mem_ack_i arrives in the same cycle the timeout would fire, the ack SHALL win and the write SHALL count as completed.
- REQ-030 timeout_clr_i SHALL clear timeout_o; if a clear and a new timeout occur in the same cycle, the set SHALL win.
- REQ-031 Deasserting enable_i SHALL stop new fetches only; an entry already in LATCH or WRITE SHALL complete normally.
- REQ-032 Data entries received before any address entry SHALL write starting at address 0.

Reset

- REQ-033 While rst_n_i is low, the following SHALL be forced asynchronously:
  - state to IDLE;
  - cur_addr, wr_count_o, mem_addr_o, mem_data_o and the timeout counter to 0;
  - mem_we_o, busy_o and timeout_o to 0.
- REQ-034 fifo_rd_req_o SHALL be 0 during reset.
- REQ-035 A reset asserted during WRITE SHALL drop mem_we_o immediately, and the pending write SHALL be lost.

Structure

- REQ-036 A shared package memacc_seq_pkg SHALL hold:
  - the FSM state type;
  - the entry-type constants c_AD_SEL_ADDR = 0 and c_AD_SEL_DATA = 1;
  - the FIFO CSR bit constants c_FIFO_FULL = 16 and c_FIFO_EMPTY = 17.
- REQ-037 The block SHALL be a single module with no sub-modules; the timeout counter SHALL be inline.

Verification

- REQ-038 Basic address-then-write sequence:
  - Stimulus: FIFO holds {addr 0x100}, {data 0xA}, {data 0xB}; memory acks in the first WRITE cycle.
  - Required response: writes 0x100 <- 0xA and 0x101 <- 0xB, then cur_addr = 0x102 and wr_count = 2.
- REQ-039 Delayed ack:
  - Stimulus: mem_ack_i is delayed 5 cycles.
  - Required response: mem_we_o stays high with addr/data stable for 6 cycles, then the write completes once.
- REQ-040 Timeout:
  - Stimulus: g_timeout = 8 and no ack.
  - Required response: timeout_o rises after 8 WRITE cycles, wr_count and cur_addr are unchanged, and timeout_clr_i clears the flag.
- REQ-041 Address wrap:
  - Stimulus: addr 0xFFFFFFFF followed by 2 data entries.
  - Required response: writes go to 0xFFFFFFFF then 0x00000000.
- REQ-042 Enable low:
  - Stimulus: enable_i dropped while in WRITE.
  - Required response: the current write completes and no further fifo_rd_req_o is issued until enable_i returns high.
- REQ-043 Reset mid-write:
  - Stimulus: rst_n_i pulsed low during WRITE.
  - Required response: mem_we_o falls asynchronously and all outputs return to 0.
